// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target register file.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } i2c_tgt_state_e;

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Local-side port bundle of the I2C target: register read port, write-event strobe and busy flag.
interface i2c_target_regfile_if
    import i2c_pkg::*;
#(
    parameter int ADDR_W = 4
);

    logic [ADDR_W-1:0]     loc_addr;
    logic [I2C_BYTE_W-1:0] loc_rdata;
    logic                  wr_strobe;
    logic [ADDR_W-1:0]     wr_addr;
    logic [I2C_BYTE_W-1:0] wr_data;
    logic                  busy;

    modport master (output loc_addr, input loc_rdata, wr_strobe, wr_addr, wr_data, busy);
    modport slave  (input loc_addr, output loc_rdata, wr_strobe, wr_addr, wr_data, busy);

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises the raw scl/sda pins and derives SCL edge and START/STOP condition pulses.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Reset to the idle-bus level so leaving reset never fakes a START.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s       = scl_sync_q[SYNC_STAGES-1];
    assign sda_s       = sda_sync_q[SYNC_STAGES-1];
    assign sda_o       = sda_s;
    assign scl_rise_o  = scl_s & ~scl_prev_q;
    assign scl_fall_o  = ~scl_s & scl_prev_q;
    assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file: pointer write, data write and auto-incrementing read.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42,
    parameter int                    NUM_REGS    = 16,
    parameter int                    SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 scl,
    inout wire                  sda,
    i2c_target_regfile_if.slave loc
);

    localparam int PTR_W = $clog2(NUM_REGS);

    i2c_tgt_state_e        state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  rw_q, rw_d;
    logic                  oe_q, oe_d;
    logic                  busy_q, busy_d;
    logic                  strobe_q, strobe_d;
    logic [PTR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [I2C_BYTE_W-1:0] wr_data_q, wr_data_d;
    logic [I2C_BYTE_W-1:0] regs_q [NUM_REGS];

    logic                  sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [I2C_BYTE_W-1:0] byte_in;
    logic [I2C_BYTE_W-1:0] rd_byte;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (scl),
        .sda_i       (sda),
        .sda_o       (sda_s),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det)
    );

    assign byte_in = {shift_q[I2C_BYTE_W-2:0], sda_s};
    assign rd_byte = regs_q[ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            strobe_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // NOTE: the register file is reset because its cleared contents are architecturally visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (strobe_d) begin
            regs_q[wr_addr_d] <= wr_data_d;
        end
    end

    // Bits shift in on every SCL rise; byte boundaries act on rise (bit_cnt 7) and the drive on fall.
    // NOTE: every next-state variable is defaulted first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (scl_rise && state_q != IDLE) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            case (state_q)
                ADDR: if (bit_cnt_q == 4'd7) begin
                    if (byte_in[I2C_BYTE_W-1:1] == TARGET_ADDR) rw_d = byte_in[0];
                    else state_d = IDLE;
                end
                PTR: if (bit_cnt_q == 4'd7) ptr_d = byte_in[PTR_W-1:0];
                WR_DATA: if (bit_cnt_q == 4'd7) begin
                    strobe_d  = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = byte_in;
                    ptr_d     = ptr_q + PTR_W'(1);
                end
                RD_ACK: begin
                    ptr_d = ptr_q + PTR_W'(1);
                    if (sda_s) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                ADDR, PTR, WR_DATA: if (bit_cnt_q == 4'd8) begin
                    state_d   = (state_q == ADDR) ? ADDR_ACK : (state_q == PTR) ? PTR_ACK : WR_ACK;
                    bit_cnt_d = '0;
                    oe_d      = 1'b1;
                    if (state_q == ADDR) busy_d = 1'b1;
                end
                ADDR_ACK, RD_ACK: begin
                    bit_cnt_d = '0;
                    if (state_q == RD_ACK || rw_q) begin
                        state_d = RD_DATA;
                        shift_d = rd_byte;
                        oe_d    = ~rd_byte[I2C_BYTE_W-1];
                    end else begin
                        state_d = PTR;
                        oe_d    = 1'b0;
                    end
                end
                PTR_ACK, WR_ACK: begin
                    state_d   = WR_DATA;
                    bit_cnt_d = '0;
                    oe_d      = 1'b0;
                end
                RD_DATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        state_d   = RD_ACK;
                        bit_cnt_d = '0;
                        oe_d      = 1'b0;
                    end else begin
                        oe_d = ~shift_q[I2C_BYTE_W-1];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        loc.loc_rdata = regs_q[loc.loc_addr];
        loc.wr_strobe = strobe_q;
        loc.wr_addr   = wr_addr_q;
        loc.wr_data   = wr_data_q;
        loc.busy      = busy_q;
    end

    assign sda = oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C controller, register-file model and strobe scoreboard.
module tb_i2c_target_regfile;

    localparam int         NREGS = 16;
    localparam int         AW    = 4;
    localparam int         Q     = 5;
    localparam logic [6:0] TADDR = 7'h42;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic scl     = 1'b1;
    logic sda_low = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;
    always #5 clk = ~clk;

    i2c_target_regfile_if #(.ADDR_W(AW)) loc_if ();

    i2c_target_regfile #(.TARGET_ADDR(TADDR), .NUM_REGS(NREGS), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .scl (scl),
        .sda (sda),
        .loc (loc_if)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mregs [NREGS];
    int          mptr;
    logic [7:0]  tx_buf [8];
    logic [11:0] exp_q [$];
    logic [11:0] got_q [$];

    typedef struct {
        logic [6:0] addr;
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_nack;
        logic       exp_busy;
        int         idx0;
        int         idx1;
        logic [7:0] exp_r0;
        logic [7:0] exp_r1;
    } wr_vec_t;

    always @(negedge clk) if (loc_if.wr_strobe) got_q.push_back({loc_if.wr_addr, loc_if.wr_data});

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation still running at time %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic s);
        sda_low = ~b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        s = sda;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_start();
        sda_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(2 * Q);
        sda_low = 1'b1;
        wait_clk(2 * Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(2 * Q);
        sda_low = 1'b0;
        wait_clk(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, nack);
    endtask

    task automatic recv_byte(input logic nack_out, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(nack_out, s);
    endtask

    function automatic void model_write(input logic [7:0] p, input int n);
        mptr = int'(p) % NREGS;
        for (int i = 0; i < n; i++) begin
            mregs[mptr] = tx_buf[i];
            exp_q.push_back({AW'(mptr), tx_buf[i]});
            mptr = (mptr + 1) % NREGS;
        end
    endfunction

    task automatic compare_strobes(input string tag);
        check({tag, "_strobe_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) check({tag, "_strobe"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < NREGS; a++) begin
            loc_if.loc_addr = AW'(a);
            #1;
            check($sformatf("%s_loc_rdata[%0d]", tag, a), loc_if.loc_rdata, mregs[a]);
        end
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int n,
                            output logic a_nack, output logic busy_seen, output logic d_nack);
        logic nk;
        i2c_start();
        send_byte({a, 1'b0}, a_nack);
        busy_seen = loc_if.busy;
        d_nack = 1'b0;
        if (!a_nack) begin
            send_byte(p, nk);
            d_nack |= nk;
            for (int i = 0; i < n; i++) begin
                send_byte(tx_buf[i], nk);
                d_nack |= nk;
            end
        end
        i2c_stop();
    endtask

    task automatic do_read(input string tag, input logic [7:0] p, input int n);
        logic nk;
        logic [7:0] d;
        i2c_start();
        send_byte({TADDR, 1'b0}, nk);
        check({tag, "_addr_w_ack"}, nk, 1'b0);
        send_byte(p, nk);
        check({tag, "_ptr_ack"}, nk, 1'b0);
        mptr = int'(p) % NREGS;
        i2c_start();
        send_byte({TADDR, 1'b1}, nk);
        check({tag, "_addr_r_ack"}, nk, 1'b0);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, d);
            check($sformatf("%s_rd_byte%0d", tag, i), d, mregs[mptr]);
            mptr = (mptr + 1) % NREGS;
        end
        check({tag, "_sda_released"}, sda, 1'b1);
        check({tag, "_busy_after_nack"}, loc_if.busy, 1'b0);
        i2c_stop();
    endtask

    initial begin
        wr_vec_t    vecs [5];
        logic       a_nack, busy_seen, d_nack, nk, s;
        logic [7:0] addr_w;
        int         n;

        vecs[0] = '{7'h42, 8'h03, 8'hA5, 8'h5A, 1'b0, 1'b1, 3, 4, 8'hA5, 8'h5A};
        vecs[1] = '{7'h43, 8'h00, 8'h77, 8'h88, 1'b1, 1'b0, 3, 4, 8'hA5, 8'h5A};
        vecs[2] = '{7'h42, 8'h0F, 8'h11, 8'h22, 1'b0, 1'b1, 15, 0, 8'h11, 8'h22};
        vecs[3] = '{7'h42, 8'h1F, 8'h33, 8'h44, 1'b0, 1'b1, 15, 0, 8'h33, 8'h44};
        vecs[4] = '{7'h02, 8'h05, 8'hEE, 8'hFF, 1'b1, 1'b0, 15, 0, 8'h33, 8'h44};
        for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
        mptr = 0;
        loc_if.loc_addr = '0;

        // Reset state
        wait_clk(3);
        check("rst_sda", sda, 1'b1);
        check("rst_busy", loc_if.busy, 1'b0);
        check("rst_wr_strobe", loc_if.wr_strobe, 1'b0);
        rst = 1'b0;
        wait_clk(5);
        sweep("rst");

        // Table-driven write transactions
        for (int v = 0; v < 5; v++) begin
            tx_buf[0] = vecs[v].d0;
            tx_buf[1] = vecs[v].d1;
            do_write(vecs[v].addr, vecs[v].ptr, 2, a_nack, busy_seen, d_nack);
            if (!vecs[v].exp_nack) model_write(vecs[v].ptr, 2);
            check($sformatf("vec%0d_addr_ack", v), a_nack, vecs[v].exp_nack);
            check($sformatf("vec%0d_busy", v), busy_seen, vecs[v].exp_busy);
            check($sformatf("vec%0d_data_ack", v), d_nack, 1'b0);
            check($sformatf("vec%0d_busy_idle", v), loc_if.busy, 1'b0);
            check($sformatf("vec%0d_sda_idle", v), sda, 1'b1);
            compare_strobes($sformatf("vec%0d", v));
            loc_if.loc_addr = AW'(vecs[v].idx0);
            #1;
            check($sformatf("vec%0d_reg_a", v), loc_if.loc_rdata, vecs[v].exp_r0);
            loc_if.loc_addr = AW'(vecs[v].idx1);
            #1;
            check($sformatf("vec%0d_reg_b", v), loc_if.loc_rdata, vecs[v].exp_r1);
        end

        // Pointer write, repeated START, read three bytes ACK,ACK,NACK
        do_read("rd3", 8'h02, 3);

        // STOP after four data bits: nothing committed
        i2c_start();
        send_byte({TADDR, 1'b0}, nk);
        check("t5_addr_ack", nk, 1'b0);
        send_byte(8'h06, nk);
        check("t5_ptr_ack", nk, 1'b0);
        mptr = 6;
        send_bit(1'b1, s);
        send_bit(1'b0, s);
        send_bit(1'b1, s);
        send_bit(1'b1, s);
        i2c_stop();
        check("t5_sda", sda, 1'b1);
        check("t5_busy", loc_if.busy, 1'b0);
        compare_strobes("t5_abort");
        tx_buf[0] = 8'h9C;
        do_write(TADDR, 8'h06, 1, a_nack, busy_seen, d_nack);
        model_write(8'h06, 1);
        check("t5_next_addr_ack", a_nack, 1'b0);
        check("t5_next_data_ack", d_nack, 1'b0);
        compare_strobes("t5_next");

        // Randomised writes and reads against the model
        for (int t = 0; t < 10; t++) begin
            n = int'($urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
                addr_w = 8'($urandom);
                do_write(TADDR, addr_w, n, a_nack, busy_seen, d_nack);
                model_write(addr_w, n);
                check($sformatf("rnd%0d_addr_ack", t), a_nack, 1'b0);
                check($sformatf("rnd%0d_data_ack", t), d_nack, 1'b0);
                compare_strobes($sformatf("rnd%0d", t));
            end else begin
                do_read($sformatf("rnd%0d", t), 8'($urandom), n);
            end
        end
        sweep("rnd");

        // Reset while the target pulls the address ACK low
        addr_w = {TADDR, 1'b0};
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(addr_w[i], s);
        sda_low = 1'b0;
        wait_clk(1);
        check("t6_ack_driven", sda, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_sda_released_in_rst", sda, 1'b1);
        wait_clk(2);
        check("t6_busy", loc_if.busy, 1'b0);
        check("t6_wr_strobe", loc_if.wr_strobe, 1'b0);
        rst = 1'b0;
        wait_clk(3);
        for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
        mptr = 0;
        got_q.delete();
        sweep("t6");
        i2c_stop();
        tx_buf[0] = 8'h3C;
        do_write(TADDR, 8'h07, 1, a_nack, busy_seen, d_nack);
        model_write(8'h07, 1);
        check("t6_after_addr_ack", a_nack, 1'b0);
        check("t6_after_data_ack", d_nack, 1'b0);
        compare_strobes("t6_after");
        sweep("t6_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
